// File: rtl/layer_2_pkg.sv
// Shared constants and FSM encoding for the layer-2 argmax reader.
// Also intended for reuse by the bias-add stage testbench.
package layer_2_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int IDX_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/layer_2_argmax_reader_signed_max_compare.sv
// Combinational strictly-greater signed max step.
// Keeps the incumbent on ties so the lowest index wins.
module signed_max_compare #(
    parameter int SIZE  = 16,
    parameter int IDX_W = 4
) (
    input  logic [SIZE-1:0]  cand_val,
    input  logic [IDX_W-1:0] cand_idx,
    input  logic [SIZE-1:0]  best_val,
    input  logic [IDX_W-1:0] best_idx,
    output logic [SIZE-1:0]  next_val,
    output logic [IDX_W-1:0] next_idx
);

    logic greater;

    assign greater  = $signed(cand_val) > $signed(best_val);
    assign next_val = greater ? cand_val : best_val;
    assign next_idx = greater ? cand_idx : best_idx;

endmodule

// File: rtl/layer_2_argmax_reader.sv
// Snapshots ten class scores on start and scans them one per cycle.
// Optional macro LAYER_2_ARGMAX_ONEHOT_EN adds a registered one-hot output.
module layer_2_argmax_reader
    import layer_2_pkg::*;
#(
    parameter int SIZE = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [SIZE-1:0]  layer_2_score_1,
    input  logic [SIZE-1:0]  layer_2_score_2,
    input  logic [SIZE-1:0]  layer_2_score_3,
    input  logic [SIZE-1:0]  layer_2_score_4,
    input  logic [SIZE-1:0]  layer_2_score_5,
    input  logic [SIZE-1:0]  layer_2_score_6,
    input  logic [SIZE-1:0]  layer_2_score_7,
    input  logic [SIZE-1:0]  layer_2_score_8,
    input  logic [SIZE-1:0]  layer_2_score_9,
    input  logic [SIZE-1:0]  layer_2_score_10,
`ifdef LAYER_2_ARGMAX_ONEHOT_EN
    output logic [NUM_CLASSES-1:0] class_onehot,
`endif
    output logic [IDX_W-1:0] class_idx,
    output logic [SIZE-1:0]  max_value,
    output logic             valid,
    output logic             busy
);

    state_t state, next_state;

    logic [SIZE-1:0]  scores [NUM_CLASSES];
    logic [SIZE-1:0]  snap   [NUM_CLASSES];
    logic [SIZE-1:0]  best_val, cmp_val;
    logic [IDX_W-1:0] best_idx, cmp_idx;
    logic [IDX_W-1:0] counter;
    logic             load, step, finish, last;

    assign scores[0] = layer_2_score_1;
    assign scores[1] = layer_2_score_2;
    assign scores[2] = layer_2_score_3;
    assign scores[3] = layer_2_score_4;
    assign scores[4] = layer_2_score_5;
    assign scores[5] = layer_2_score_6;
    assign scores[6] = layer_2_score_7;
    assign scores[7] = layer_2_score_8;
    assign scores[8] = layer_2_score_9;
    assign scores[9] = layer_2_score_10;

    assign last = counter == IDX_W'(NUM_CLASSES - 1);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SCAN;
            SCAN:    if (last)  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        load   = (state == IDLE) && start;
        step   = (state == SCAN);
        finish = (state == DONE);
    end

    signed_max_compare #(
        .SIZE  (SIZE),
        .IDX_W (IDX_W)
    ) u_cmp (
        .cand_val (snap[counter]),
        .cand_idx (counter),
        .best_val (best_val),
        .best_idx (best_idx),
        .next_val (cmp_val),
        .next_idx (cmp_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CLASSES; i++) snap[i] <= '0;
            best_val  <= '0;
            best_idx  <= '0;
            counter   <= '0;
            class_idx <= '0;
            max_value <= '0;
            valid     <= 1'b0;
`ifdef LAYER_2_ARGMAX_ONEHOT_EN
            class_onehot <= '0;
`endif
        end else begin
            valid <= finish;
            if (load) begin
                for (int i = 0; i < NUM_CLASSES; i++) snap[i] <= scores[i];
                best_val <= scores[0];
                best_idx <= '0;
                counter  <= IDX_W'(1);
            end
            if (step) begin
                best_val <= cmp_val;
                best_idx <= cmp_idx;
                counter  <= last ? '0 : counter + IDX_W'(1);
            end
            if (finish) begin
                class_idx <= best_idx;
                max_value <= best_val;
`ifdef LAYER_2_ARGMAX_ONEHOT_EN
                class_onehot           <= '0;
                class_onehot[best_idx] <= 1'b1;
`endif
            end
        end
    end

    // busy covers the scan, the DONE cycle and the valid cycle that follows
    assign busy = (state != IDLE) || valid;

endmodule
